// File: rtl/rsa_core_pkg.sv
// Shared definitions for the RSA core datapath: divider FSM encodings,
// control polarity constants and a constant-width helper.
package rsa_core_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      DONE = 3'd2
   } div_state_e;

   localparam logic START_ACTIVE = 1'b1;
   localparam logic RESET_ACTIVE = 1'b1;

   // Bits needed to hold values 0 .. value-1 (minimum 1).
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int v = value - 1; v > 0; v = v >> 1) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/rsa_core_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module rsa_core_div_step #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH:0]   rem,
   input  logic                  dvd_msb,
   input  logic [DATA_WIDTH-1:0] dvs,
   output logic [DATA_WIDTH:0]   rem_next,
   output logic                  q_bit
);

   logic [DATA_WIDTH:0] shifted;
   // The remainder MSB is shifted out every iteration by construction.
   logic                unused_rem_msb;

   assign unused_rem_msb = rem[DATA_WIDTH];

   always_comb begin
      shifted  = {rem[DATA_WIDTH-1:0], dvd_msb};
      q_bit    = (shifted >= {1'b0, dvs});
      rem_next = q_bit ? (shifted - {1'b0, dvs}) : shifted;
   end

endmodule

// File: rtl/rsa_core_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional build macro: RSA_CORE_DIV_EARLY_EXIT_EN (skip CALC when dividend < divisor).
module rsa_core_div
   import rsa_core_pkg::*;
#(
   parameter int   DATA_WIDTH = 8,
   parameter logic START      = START_ACTIVE
) (
   input  logic                    div_clk,
   input  logic                    div_rst,
   input  logic                    div_start,
   input  logic [2*DATA_WIDTH-1:0] div_a,
   input  logic [DATA_WIDTH-1:0]   div_b,
   output logic                    div_busy,
   output logic                    div_done,
   output logic [2*DATA_WIDTH-1:0] div_q,
   output logic [DATA_WIDTH-1:0]   div_r,
   output logic                    div_dbz
);

   localparam int             QW   = 2 * DATA_WIDTH;
   localparam int             CW   = clog2(QW + 1);
   localparam logic [CW-1:0]  LAST = CW'(QW - 1);

   div_state_e            state_r, state_nxt;
   logic [QW-1:0]         dvd_r;
   logic [DATA_WIDTH-1:0] dvs_r;
   logic [DATA_WIDTH:0]   rem_r, rem_nxt;
   logic [CW-1:0]         cnt_r;
   logic                  q_bit;
   logic                  is_idle, is_calc, start_hit, last;
`ifdef RSA_CORE_DIV_EARLY_EXIT_EN
   logic                  early_hit;
   assign early_hit = (div_a < {{DATA_WIDTH{1'b0}}, div_b});
`endif

   rsa_core_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem      (rem_r),
      .dvd_msb  (dvd_r[QW-1]),
      .dvs      (dvs_r),
      .rem_next (rem_nxt),
      .q_bit    (q_bit)
   );

   // Unused encodings behave exactly like IDLE.
   assign is_calc   = (state_r == CALC);
   assign is_idle   = !(is_calc || state_r == DONE);
   assign start_hit = (div_start == START);
   assign last      = (cnt_r == LAST);

   always_ff @(posedge div_clk or posedge div_rst) begin
      if (div_rst) state_r <= IDLE;
      else         state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      if (is_idle) begin
         state_nxt = IDLE;
         if (start_hit) begin
            state_nxt = CALC;
`ifdef RSA_CORE_DIV_EARLY_EXIT_EN
            if (early_hit) state_nxt = DONE;
`endif
         end
      end else if (is_calc) begin
         div_busy = 1'b1;
         if (last) state_nxt = DONE;
      end else begin
         div_done  = 1'b1;
         state_nxt = IDLE;
      end
   end

   // The dividend register shifts quotient bits in from the LSB side, so it
   // holds the full quotient once the last dividend bit has been consumed.
   always_ff @(posedge div_clk or posedge div_rst) begin
      if (div_rst) begin
         dvd_r   <= '0;
         dvs_r   <= '0;
         rem_r   <= '0;
         cnt_r   <= '0;
         div_q   <= '0;
         div_r   <= '0;
         div_dbz <= 1'b0;
      end else if (is_idle) begin
         if (start_hit) begin
            dvd_r <= div_a;
            dvs_r <= div_b;
            rem_r <= '0;
            cnt_r <= '0;
`ifdef RSA_CORE_DIV_EARLY_EXIT_EN
            if (early_hit) begin
               div_q   <= '0;
               div_r   <= div_a[DATA_WIDTH-1:0];
               div_dbz <= 1'b0;
            end
`endif
         end
      end else if (is_calc) begin
         dvd_r <= {dvd_r[QW-2:0], q_bit};
         rem_r <= rem_nxt;
         cnt_r <= cnt_r + 1'b1;
         if (last) begin
            div_q   <= {dvd_r[QW-2:0], q_bit};
            div_r   <= rem_nxt[DATA_WIDTH-1:0];
            div_dbz <= (dvs_r == '0);
         end
      end
   end

endmodule

// File: tb/tb_rsa_core_div.sv
// Self-checking bench for rsa_core_div: directed and random divisions scored
// against a queue of expected results, plus restart-ignore and reset-abort cases.
module tb_rsa_core_div;

   localparam int DW     = 8;
   localparam int QW     = 2 * DW;
   localparam int BUDGET = 4 * DW + 8;

   logic          div_clk = 1'b0;
   logic          div_rst;
   logic          div_start;
   logic [QW-1:0] div_a;
   logic [DW-1:0] div_b;
   logic          div_busy, div_done, div_dbz;
   logic [QW-1:0] div_q;
   logic [DW-1:0] div_r;

   always #5 div_clk = ~div_clk;

   rsa_core_div #(.DATA_WIDTH(DW), .START(1'b1)) dut (
      .div_clk   (div_clk),
      .div_rst   (div_rst),
      .div_start (div_start),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_busy  (div_busy),
      .div_done  (div_done),
      .div_q     (div_q),
      .div_r     (div_r),
      .div_dbz   (div_dbz)
   );

   typedef struct {
      logic [QW-1:0] a;
      logic [DW-1:0] b;
      logic [QW-1:0] q;
      logic [DW-1:0] r;
      logic          dbz;
      int            edges;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Posedges after the start edge until div_done is visible.
   function automatic int exp_edges(input logic [QW-1:0] a, input logic [DW-1:0] b);
`ifdef RSA_CORE_DIV_EARLY_EXIT_EN
      return (a < {{(QW-DW){1'b0}}, b}) ? 0 : QW;
`else
      return (a == a && b == b) ? QW : QW;
`endif
   endfunction

   task automatic push_exp(input logic [QW-1:0] a, input logic [DW-1:0] b,
                           input logic [QW-1:0] q, input logic [DW-1:0] r, input logic dbz);
      exp_t e;
      e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz; e.edges = exp_edges(a, b);
      sb.push_back(e);
   endtask

   task automatic push_model(input logic [QW-1:0] a, input logic [DW-1:0] b);
      logic [QW-1:0] rr;
      if (b == '0) begin
         push_exp(a, b, '1, a[DW-1:0], 1'b1);
      end else begin
         rr = a % {{(QW-DW){1'b0}}, b};
         push_exp(a, b, a / {{(QW-DW){1'b0}}, b}, rr[DW-1:0], 1'b0);
      end
   endtask

   task automatic launch(input logic [QW-1:0] a, input logic [DW-1:0] b);
      @(negedge div_clk);
      div_a     = a;
      div_b     = b;
      div_start = 1'b1;
      @(posedge div_clk);
      #1 div_start = 1'b0;
   endtask

   // Waits for div_done, scores it against the queue head; optionally re-pulses
   // start with new operands at negedge index disturb_at.
   task automatic wait_result(input int disturb_at);
      exp_t e;
      bit   seen;
      int   k;
      seen = 1'b0;
      if (sb.size() == 0) begin
         tests++; fails++;
         $error("FAIL sb_empty: observed 0 entries, expected at least 1");
         return;
      end
      e = sb.pop_front();
      for (k = 0; k < BUDGET; k++) begin
         @(negedge div_clk);
         if (k == disturb_at) begin
            div_start = 1'b1;
            div_a     = ~div_a;
            div_b     = div_b + 8'd3;
         end
         if (k == disturb_at + 1) div_start = 1'b0;
         if (k == 0 && e.edges > 0) check("busy_calc", 32'(div_busy), 32'd1);
         if (div_done) begin
            seen = 1'b1;
            break;
         end
      end
      div_start = 1'b0;
      if (!seen) begin
         tests++; fails++;
         $error("FAIL timeout: observed no div_done in %0d cycles, expected one", BUDGET);
      end else begin
         check("latency", 32'(k), 32'(e.edges));
         check("div_q", 32'(div_q), 32'(e.q));
         check("div_r", 32'(div_r), 32'(e.r));
         check("div_dbz", 32'(div_dbz), 32'(e.dbz));
         check("busy_done", 32'(div_busy), 32'd0);
         if (e.b != '0) begin
            check("inv_sum", 32'(div_q) * 32'(div_b_of(e)) + 32'(div_r), 32'(e.a));
            check("inv_rlt", 32'(div_r < e.b), 32'd1);
         end
         @(negedge div_clk);
         check("done_pulse", 32'(div_done), 32'd0);
      end
   endtask

   function automatic logic [DW-1:0] div_b_of(input exp_t e);
      return e.b;
   endfunction

   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge div_clk);
         if (div_done) cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            extra;
      logic [QW-1:0] ra;
      logic [DW-1:0] rb;

      div_rst   = 1'b1;
      div_start = 1'b0;
      div_a     = '0;
      div_b     = '0;
      #12;
      check("rst_busy", 32'(div_busy), 32'd0);
      check("rst_done", 32'(div_done), 32'd0);
      check("rst_q", 32'(div_q), 32'd0);
      check("rst_r", 32'(div_r), 32'd0);
      check("rst_dbz", 32'(div_dbz), 32'd0);
      @(negedge div_clk);
      div_rst = 1'b0;

      push_exp(16'h0D5A, 8'h17, 16'h0094, 8'h0E, 1'b0);
      launch(16'h0D5A, 8'h17);
      wait_result(-10);

      push_exp(16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0);
      launch(16'hFE01, 8'hFF);
      wait_result(-10);

      push_exp(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
      launch(16'hFFFF, 8'h01);
      wait_result(-10);

      push_exp(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
      launch(16'h1234, 8'h00);
      wait_result(-10);

      push_exp(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0);
      launch(16'h0005, 8'h09);
      wait_result(-10);

      // Start re-pulsed with different operands mid-calculation.
      push_exp(16'h0D5A, 8'h17, 16'h0094, 8'h0E, 1'b0);
      launch(16'h0D5A, 8'h17);
      wait_result(5);
      count_dones(QW + 4, extra);
      check("no_second_done", 32'(extra), 32'd0);

      // Asynchronous reset in the middle of a calculation.
      launch(16'hABCD, 8'h3C);
      repeat (7) @(negedge div_clk);
      #2 div_rst = 1'b1;
      #1;
      check("abort_busy", 32'(div_busy), 32'd0);
      check("abort_done", 32'(div_done), 32'd0);
      check("abort_q", 32'(div_q), 32'd0);
      check("abort_r", 32'(div_r), 32'd0);
      check("abort_dbz", 32'(div_dbz), 32'd0);
      @(negedge div_clk);
      div_rst = 1'b0;
      count_dones(QW + 4, extra);
      check("abort_no_done", 32'(extra), 32'd0);

      push_exp(16'hABCD, 8'h3C, 16'h02DD, 8'h01, 1'b0);
      launch(16'hABCD, 8'h3C);
      wait_result(-10);

      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom);
         rb = 8'($urandom_range(0, 255));
         if (i == 0) ra = {8'h00, ra[7:0]};
         push_model(ra, rb);
         launch(ra, rb);
         wait_result(-10);
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
